// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per frame (start, LSB-first data,
// optional parity, 1-2 stop bits) paced by a one-clk bit-rate tick.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ 1'(PARITY_ODD);
          state_d  = S_SYNC;
        end
      end
      // Waiting here puts the start bit on the tick grid, so it lasts a full period.
      S_SYNC: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == S_IDLE);
  assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8E1, 8O1, 7N2) checked against
// a frame-level model of the expected line waveform.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] tx_data [4];
  logic [3:0] tx_valid = '0;
  logic [3:0] tx_ready;
  logic [3:0] tx_line;
  logic [3:0] tx_busy;
  logic [3:0] tx_done;

  int tick_div = 16;
  int tick_cnt = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  int cfg_bits [4] = '{8, 8, 8, 7};
  int cfg_par  [4] = '{0, 1, 1, 0};
  int cfg_odd  [4] = '{0, 0, 1, 0};
  int cfg_stop [4] = '{1, 1, 1, 2};

  bit exp_bits [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick = 1'b1;
      tick_cnt = 0;
    end else begin
      tick = 1'b0;
      tick_cnt = tick_cnt + 1;
    end
  end

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx_line[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx_line[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx(tx_line[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
  uart_tx #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx(tx_line[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

  // Expected line levels, one entry per bit period, straight from the frame format.
  function automatic void build_frame(input int idx, input logic [7:0] d);
    int ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < cfg_bits[idx]; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfg_par[idx] != 0)
      exp_bits.push_back(bit'((ones + cfg_odd[idx]) % 2));
    for (int i = 0; i < cfg_stop[idx]; i++) exp_bits.push_back(1'b1);
  endfunction

  task automatic send(input int idx, input logic [7:0] d);
    bit ok = 0;
    for (int b = 0; b < 64 * tick_div + 8; b++) begin
      @(negedge clk);
      if (tx_ready[idx] === 1'b1) begin
        ok = 1;
        break;
      end
    end
    tx_data[idx]  = d;
    tx_valid[idx] = 1'b1;
    @(negedge clk);
    tx_valid[idx] = 1'b0;
    n_checks++;
    if (!ok || tx_busy[idx] !== 1'b1)
      $display("FAIL accept[%0d]: ready_seen=%0d busy=%b, required ready_seen=1 busy=1", idx, ok, tx_busy[idx]);
    else n_pass++;
  endtask

  task automatic check_frame(input int idx, input logic [7:0] d, input bit scribble,
                             output int fall_cyc, output int done_cyc);
    int  p = tick_div;
    bit  seen = 0;
    bit  bad;
    logic [3:0] got;
    build_frame(idx, d);
    fall_cyc = 0;
    done_cyc = 0;
    for (int b = 0; b < 4 * p + 8; b++) begin
      @(negedge clk);
      if (tx_line[idx] === 1'b0) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL frame_start[%0d]: tx never fell, required a start bit", idx);
      return;
    end
    n_pass++;
    fall_cyc = cyc;
    for (int k = 0; k < exp_bits.size(); k++) begin
      bad = 0;
      got = '0;
      for (int c = 0; c < p; c++) begin
        if (k > 0 || c > 0) @(negedge clk);
        if (scribble) tx_data[idx] = 8'($urandom);
        if (!bad && (tx_line[idx] !== exp_bits[k] || tx_ready[idx] !== 1'b0 ||
                     tx_busy[idx] !== 1'b1 || tx_done[idx] !== 1'b0)) begin
          bad = 1;
          got = {tx_line[idx], tx_ready[idx], tx_busy[idx], tx_done[idx]};
        end
      end
      n_checks++;
      if (bad)
        $display("FAIL frame_bit[%0d] data=%h bit %0d: {tx,ready,busy,done}=%b, required %b010",
                 idx, d, k, got, exp_bits[k]);
      else n_pass++;
    end
    @(negedge clk);
    done_cyc = cyc;
    n_checks++;
    if ({tx_done[idx], tx_ready[idx], tx_line[idx]} !== 3'b111)
      $display("FAIL frame_done[%0d]: {done,ready,tx}=%b, required 111", idx,
               {tx_done[idx], tx_ready[idx], tx_line[idx]});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx_done[idx] !== 1'b0)
      $display("FAIL done_width[%0d]: tx_done=%b, required 0", idx, tx_done[idx]);
    else n_pass++;
  endtask

  task automatic check_idle(input int idx, input int n, input string name);
    bit bad = 0;
    logic [3:0] got = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!bad && {tx_line[idx], tx_ready[idx], tx_busy[idx], tx_done[idx]} !== 4'b1100) begin
        bad = 1;
        got = {tx_line[idx], tx_ready[idx], tx_busy[idx], tx_done[idx]};
      end
    end
    n_checks++;
    if (bad) $display("FAIL %s[%0d]: {tx,ready,busy,done}=%b, required 1100", name, idx, got);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({tx_line[i], tx_ready[i], tx_busy[i], tx_done[i]} !== 4'b1100)
        $display("FAIL reset[%0d]: {tx,ready,busy,done}=%b, required 1100", i,
                 {tx_line[i], tx_ready[i], tx_busy[i], tx_done[i]});
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_8n1();
    int f, dn;
    tick_div = 16;
    send(0, 8'h55);
    check_frame(0, 8'h55, 1'b1, f, dn);
  endtask

  task automatic test_parity();
    int f, dn;
    tick_div = 16;
    send(1, 8'hA3);
    check_frame(1, 8'hA3, 1'b1, f, dn);
    send(2, 8'hA3);
    check_frame(2, 8'hA3, 1'b1, f, dn);
  endtask

  task automatic test_two_stop();
    int f, dn;
    tick_div = 16;
    send(3, 8'h7F);
    check_frame(3, 8'h7F, 1'b1, f, dn);
  endtask

  task automatic test_back_to_back();
    int f1, d1, f2, d2;
    tick_div = 16;
    @(negedge clk);
    tx_data[0]  = 8'h01;
    tx_valid[0] = 1'b1;
    for (int b = 0; b < 8 && tx_busy[0] !== 1'b1; b++) @(negedge clk);
    tx_data[0] = 8'h80;
    check_frame(0, 8'h01, 1'b0, f1, d1);
    n_checks++;
    if (tx_busy[0] !== 1'b1)
      $display("FAIL b2b_accept: tx_busy=%b after tx_done, required 1", tx_busy[0]);
    else n_pass++;
    tx_valid[0] = 1'b0;
    check_frame(0, 8'h80, 1'b1, f2, d2);
    n_checks++;
    if (f2 - d1 !== 16)
      $display("FAIL b2b_gap: start fell %0d clks after tx_done, required 16", f2 - d1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int f, dn;
    bit seen = 0;
    tick_div = 16;
    send(0, 8'hF0);
    for (int b = 0; b < 80; b++) begin
      @(negedge clk);
      if (tx_line[0] === 1'b0) begin
        seen = 1;
        break;
      end
    end
    repeat (4 * 16 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!seen || {tx_line[0], tx_ready[0], tx_busy[0], tx_done[0]} !== 4'b1100)
      $display("FAIL reset_abort: started=%0d {tx,ready,busy,done}=%b, required 1 1100", seen,
               {tx_line[0], tx_ready[0], tx_busy[0], tx_done[0]});
    else n_pass++;
    rst = 1'b0;
    check_idle(0, 3 * 16, "reset_no_done");
    send(0, 8'h0F);
    check_frame(0, 8'h0F, 1'b1, f, dn);
  endtask

  task automatic test_busy_reject();
    int f, dn;
    tick_div = 16;
    send(0, 8'h3C);
    tx_data[0]  = 8'hAA;
    tx_valid[0] = 1'b1;
    check_frame(0, 8'h3C, 1'b0, f, dn);
    n_checks++;
    if (tx_busy[0] !== 1'b1)
      $display("FAIL busy_reject_accept: tx_busy=%b after IDLE, required 1", tx_busy[0]);
    else n_pass++;
    tx_valid[0] = 1'b0;
    check_frame(0, 8'hAA, 1'b1, f, dn);
    check_idle(0, 3 * 16, "idle_ticks");
  endtask

  task automatic test_random();
    int divs [4] = '{1, 2, 5, 16};
    int f, dn, idx;
    logic [7:0] d;
    for (int n = 0; n < 24; n++) begin
      idx      = int'($urandom_range(0, 3));
      tick_div = divs[$urandom_range(0, 3)];
      d        = 8'($urandom);
      send(idx, d);
      check_frame(idx, d, 1'b1, f, dn);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_busy_reject();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; consumes the one-cycle bit-rate `tick` from the team's baud rate generator.
- Serialises one parallel word per frame onto `tx`: LSB first, start bit, optional parity, 1 or 2 stop bits.
- Upstream interface is a valid/ready handshake.
- Sits between the processor's output register/FIFO and the board TX pin; mirrors the receive path.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..8.
- PARITY_EN, 0, 1 = insert parity bit after data.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- tick  input  1  one-clk pulse per bit period, from baud rate generator.
- tx_data  input  DATA_BITS  word to send; sampled only on handshake.
- tx_valid  input  1  upstream has a word.
- tx_ready  output  1  high only in IDLE; transfer occurs when tx_valid && tx_ready on a clk edge.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-clk pulse at end of last stop bit.

Behaviour:
- Reset (rst high at posedge clk): state=IDLE, tx=1, tx_done=0, tx_busy=0, tx_ready=1.
  - Shift register, bit counter and stop counter are cleared.
  - Reset mid-frame aborts the frame: tx returns to 1 on that edge, word is discarded, no tx_done.
- State machine: IDLE, SYNC, START, DATA, PARITY, STOP. Every transition out of SYNC..STOP occurs only on a clk edge where tick=1.
- IDLE:
  - On handshake, capture tx_data into the shift register and compute the parity bit (XOR of data bits, inverted if PARITY_ODD).
  - Go to SYNC. tx stays 1.
  - tick is ignored in IDLE.
- SYNC (aligns frame to the bit grid): on tick, tx<=0 and go to START. The start bit therefore lasts exactly one tick period.
- START: on tick, tx<=data[0], bit_cnt<=0, go to DATA.
- DATA: on tick,
  - if bit_cnt==DATA_BITS-1: if PARITY_EN, tx<=parity and go to PARITY; else tx<=1 and go to STOP.
  - otherwise tx<=data[bit_cnt+1] and bit_cnt++.
- PARITY: on tick, tx<=1, go to STOP.
- STOP:
  - Stop counter starts at 0; on each tick it increments.
  - On the tick where the counter equals STOP_BITS-1: go to IDLE, tx stays 1, tx_done=1 for exactly that next cycle.
- Outputs:
  - tx_ready and tx_busy decode the state register (combinational from state).
  - tx and tx_done are registered.
- Handshake:
  - tx_valid while busy is not accepted; tx_data may change freely after capture without effect.
  - tx_valid need not stay high once accepted.
- Back-to-back frames:
  - tx_ready is high in the cycle after tx_done; a word accepted then waits in SYNC for the next tick.
  - Minimum line-idle gap between frames is therefore one extra bit period (start bit N+1 begins one tick after frame N's stop bit ends).
- Frame length from first start-bit edge to tx_done = (1 + DATA_BITS + PARITY_EN + STOP_BITS) tick periods.
- Edge cases:
  - tick coincident with the handshake edge: word is captured; SYNC waits for the following tick.
  - tick held high continuously is legal: one bit per clk.

Test Plan:
- 8N1, tick every 16 clks, send 0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1, each level held exactly 16 clks; tx_done pulses once, 1 clk, 160 clks after the start-bit falling edge; tx_ready low throughout.
- PARITY_EN=1, PARITY_ODD=0, send 0xA3 → data bits 1,1,0,0,0,1,0,1, then parity 0, then stop 1. With PARITY_ODD=1 the parity bit is 1. Frame = 11 bit periods.
- STOP_BITS=2, DATA_BITS=7, send 0x7F → start 0, seven 1s, two stop-bit periods of 1; tx_done after 10 tick periods.
- Back-to-back: hold tx_valid high with 0x01 then 0x80 → second word accepted the cycle after tx_done; line high for stop + one idle bit period; 0x80 frame decodes correctly; tx_data changes mid-frame have no effect.
- Assert rst during DATA bit 3 of 0xF0 → next edge tx=1, tx_ready=1, tx_busy=0, no tx_done pulse; a subsequent 0x0F frame transmits correctly.
- tx_valid asserted while busy with 0xAA → not accepted (tx_ready=0) until IDLE; ticks in IDLE with no valid → tx stays 1, state unchanged.
